// File: rtl/uart_wb_bridge.sv
// UART-to-Wishbone debug bridge: parses 0x57 (write) / 0x52 (read) frames and runs single 32-bit cycles.
// Optional BRIDGE_WB_TIMEOUT_EN: abandon a Wishbone cycle after wb_timeout cycles and reply NAK.
module uart_wb_bridge #(
    parameter int unsigned clk_freq     = 100000000,
    parameter int unsigned byte_timeout = 100000,
    parameter int unsigned wb_timeout   = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_avail,
    input  logic        rx_error,
    output logic        rx_ack,
    output logic [7:0]  tx_data,
    output logic        tx_wr,
    input  logic        tx_busy,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    output logic [3:0]  wb_sel_o,
    output logic        wb_we_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    input  logic        wb_ack_i
);

    // byte_timeout is already in clk cycles; a zero clk_freq marks an unclocked model and disables it
    localparam int unsigned BYTE_LIMIT = (clk_freq != 32'd0) ? byte_timeout : 32'd0;
    localparam int unsigned TMR_MAX    = (BYTE_LIMIT > wb_timeout) ? BYTE_LIMIT : wb_timeout;
    localparam int          TMR_W      = $clog2(TMR_MAX + 32'd2);

    localparam logic [7:0] CMD_WR = 8'h57;
    localparam logic [7:0] CMD_RD = 8'h52;
    localparam logic [7:0] RSP_ACK = 8'h06;
    localparam logic [7:0] RSP_NAK = 8'h15;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ADDR = 3'd1,
        ST_DATA = 3'd2,
        ST_WB   = 3'd3,
        ST_TX   = 3'd4
    } state_t;

    state_t             state_r;
    logic               is_write_r;
    logic [1:0]         byte_cnt_r;
    logic [TMR_W-1:0]   timer_r;
    logic [31:0]        reply_r;
    logic [2:0]         reply_cnt_r;
    logic               accept_s;
    logic               byte_expired_s;

    // A byte is taken only while parsing; during WB/TX it stays queued in the uart
    always_comb begin
        accept_s       = 1'b0;
        byte_expired_s = 1'b0;
        if ((state_r == ST_IDLE) || (state_r == ST_ADDR) || (state_r == ST_DATA)) begin
            accept_s = rx_avail && !rx_ack;
        end else begin
            accept_s = 1'b0;
        end
        if (BYTE_LIMIT != 32'd0) begin
            byte_expired_s = (timer_r == TMR_W'(BYTE_LIMIT - 32'd1));
        end else begin
            byte_expired_s = 1'b0;
        end
    end

    // Frame parser, Wishbone master and reply sequencer
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            is_write_r  <= 1'b0;
            byte_cnt_r  <= 2'd0;
            timer_r     <= '0;
            reply_r     <= 32'h0000_0000;
            reply_cnt_r <= 3'd0;
            rx_ack      <= 1'b0;
            tx_data     <= 8'h00;
            tx_wr       <= 1'b0;
            wb_adr_o    <= 32'h0000_0000;
            wb_dat_o    <= 32'h0000_0000;
            wb_sel_o    <= 4'h0;
            wb_we_o     <= 1'b0;
            wb_cyc_o    <= 1'b0;
            wb_stb_o    <= 1'b0;
        end else begin
            rx_ack <= 1'b0;
            tx_wr  <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    timer_r    <= '0;
                    byte_cnt_r <= 2'd0;
                    if (accept_s) begin
                        rx_ack <= 1'b1;
                        if (rx_error) begin
                            state_r <= ST_IDLE;
                        end else if (rx_data == CMD_WR) begin
                            is_write_r <= 1'b1;
                            state_r    <= ST_ADDR;
                        end else if (rx_data == CMD_RD) begin
                            is_write_r <= 1'b0;
                            state_r    <= ST_ADDR;
                        end else begin
                            reply_r     <= {RSP_NAK, 24'h00_0000};
                            reply_cnt_r <= 3'd1;
                            state_r     <= ST_TX;
                        end
                    end
                end
                ST_ADDR, ST_DATA: begin
                    if (accept_s) begin
                        rx_ack  <= 1'b1;
                        timer_r <= '0;
                        if (rx_error) begin
                            state_r <= ST_IDLE;
                        end else begin
                            byte_cnt_r <= byte_cnt_r + 2'd1;
                            if (state_r == ST_ADDR) begin
                                wb_adr_o <= {wb_adr_o[23:0], rx_data};
                            end else begin
                                wb_dat_o <= {wb_dat_o[23:0], rx_data};
                            end
                            if (byte_cnt_r == 2'd3) begin
                                if ((state_r == ST_ADDR) && is_write_r) begin
                                    state_r <= ST_DATA;
                                end else begin
                                    state_r  <= ST_WB;
                                    wb_cyc_o <= 1'b1;
                                    wb_stb_o <= 1'b1;
                                    wb_sel_o <= 4'hF;
                                    wb_we_o  <= is_write_r;
                                end
                            end
                        end
                    end else if (byte_expired_s) begin
                        state_r <= ST_IDLE;
                    end else begin
                        timer_r <= timer_r + TMR_W'(1);
                    end
                end
                ST_WB: begin
                    if (wb_ack_i) begin
                        wb_cyc_o <= 1'b0;
                        wb_stb_o <= 1'b0;
                        wb_sel_o <= 4'h0;
                        wb_we_o  <= 1'b0;
                        state_r  <= ST_TX;
                        if (is_write_r) begin
                            reply_r     <= {RSP_ACK, 24'h00_0000};
                            reply_cnt_r <= 3'd1;
                        end else begin
                            reply_r     <= wb_dat_i;
                            reply_cnt_r <= 3'd4;
                        end
                    end
`ifdef BRIDGE_WB_TIMEOUT_EN
                    else if (timer_r == TMR_W'(wb_timeout - 32'd1)) begin
                        wb_cyc_o    <= 1'b0;
                        wb_stb_o    <= 1'b0;
                        wb_sel_o    <= 4'h0;
                        wb_we_o     <= 1'b0;
                        reply_r     <= {RSP_NAK, 24'h00_0000};
                        reply_cnt_r <= 3'd1;
                        state_r     <= ST_TX;
                    end else begin
                        timer_r <= timer_r + TMR_W'(1);
                    end
`endif
                end
                ST_TX: begin
                    // tx_busy lags tx_wr by a cycle, so the cycle after a write is skipped
                    if (!tx_wr && !tx_busy) begin
                        tx_data     <= reply_r[31:24];
                        tx_wr       <= 1'b1;
                        reply_r     <= {reply_r[23:0], 8'h00};
                        reply_cnt_r <= reply_cnt_r - 3'd1;
                        if (reply_cnt_r == 3'd1) begin
                            state_r <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_wb_bridge.sv
// Randomised bench for uart_wb_bridge: frame-level reference model, memory-backed Wishbone slave, busy-modelling uart tx.
module tb_uart_wb_bridge;

    localparam int unsigned BYTE_TO = 50;
    localparam int unsigned WB_TO   = 64;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_avail;
    logic        rx_error;
    logic        rx_ack;
    logic [7:0]  tx_data;
    logic        tx_wr;
    logic        tx_busy;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [31:0] wb_dat_i;
    logic [3:0]  wb_sel_o;
    logic        wb_we_o;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_ack_i;

    uart_wb_bridge #(
        .clk_freq(100000000),
        .byte_timeout(BYTE_TO),
        .wb_timeout(WB_TO)
    ) dut (
        .clk(clk), .reset(reset),
        .rx_data(rx_data), .rx_avail(rx_avail), .rx_error(rx_error), .rx_ack(rx_ack),
        .tx_data(tx_data), .tx_wr(tx_wr), .tx_busy(tx_busy),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i), .wb_sel_o(wb_sel_o),
        .wb_we_o(wb_we_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_ack_i(wb_ack_i)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Observed traffic
    logic [31:0] log_adr[$];
    logic [31:0] log_dat[$];
    logic        log_we[$];
    logic [3:0]  log_sel[$];
    logic [7:0]  replies[$];
    // Expected traffic from the reference model
    logic [31:0] exp_adr[$];
    logic [31:0] exp_dat[$];
    logic        exp_we[$];
    logic [7:0]  exp_rep[$];

    logic [31:0] slave_mem [logic [31:0]];
    logic [31:0] ref_mem   [logic [31:0]];
    bit          slave_en = 1'b1;
    logic [7:0]  fb [0:8];
    int          fb_n;
    int          ack_dbl = 0;
    int          wr_dbl = 0;
    int          wr_busy = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Contents a never-written slave location returns
    function automatic logic [31:0] fill(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h5A5A_1234;
    endfunction

    // Wishbone slave: random 0..3 wait states, single-cycle ack
    initial begin
        int delay;
        delay    = 0;
        wb_ack_i = 1'b0;
        wb_dat_i = $urandom;
        forever begin
            @(negedge clk);
            if (wb_ack_i) begin
                wb_ack_i = 1'b0;
                wb_dat_i = $urandom;
            end else if (wb_cyc_o && wb_stb_o && slave_en) begin
                if (delay == 0) begin
                    wb_ack_i = 1'b1;
                    log_adr.push_back(wb_adr_o);
                    log_we.push_back(wb_we_o);
                    log_sel.push_back(wb_sel_o);
                    if (wb_we_o) begin
                        slave_mem[wb_adr_o] = wb_dat_o;
                        log_dat.push_back(wb_dat_o);
                    end else begin
                        wb_dat_i = slave_mem.exists(wb_adr_o) ? slave_mem[wb_adr_o] : fill(wb_adr_o);
                        log_dat.push_back(wb_dat_i);
                    end
                    delay = $urandom_range(0, 3);
                end else begin
                    delay--;
                end
            end
        end
    end

    // Uart transmitter: busy rises one cycle after tx_wr and lasts 1..4 cycles
    initial begin
        int n;
        n       = 0;
        tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (n > 0) begin
                tx_busy = 1'b1;
                n--;
            end else begin
                tx_busy = 1'b0;
            end
            if (tx_wr) n = $urandom_range(1, 4);
        end
    end

    // Capture replies and handshake protocol violations
    initial begin
        logic prev_ack, prev_wr;
        prev_ack = 1'b0;
        prev_wr  = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (tx_wr) replies.push_back(tx_data);
            if (rx_ack && prev_ack) ack_dbl++;
            if (tx_wr && prev_wr) wr_dbl++;
            if (tx_wr && tx_busy) wr_busy++;
            prev_ack = rx_ack;
            prev_wr  = tx_wr;
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic err);
        int n;
        n = 0;
        @(negedge clk);
        rx_data  = b;
        rx_error = err;
        rx_avail = 1'b1;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!rx_ack && n < 2000);
        if (!rx_ack) check_eq("rx_ack_wait", 32'd0, 32'd1);
        @(negedge clk);
        rx_avail = 1'b0;
        rx_error = 1'b0;
    endtask

    task automatic send_fb(input int err_at, input int gap_at, input int gap_len);
        for (int i = 0; i < fb_n; i++) begin
            if (i == gap_at) repeat (gap_len) @(posedge clk);
            send_byte(fb[i], (i == err_at));
        end
    endtask

    task automatic compare_frame(input string tag);
        int n;
        check_eq({tag, ".wb_n"}, 32'(log_adr.size()), 32'(exp_adr.size()));
        n = (log_adr.size() < exp_adr.size()) ? log_adr.size() : exp_adr.size();
        for (int i = 0; i < n; i++) begin
            check_eq($sformatf("%s.adr%0d", tag, i), log_adr[i], exp_adr[i]);
            check_eq($sformatf("%s.dat%0d", tag, i), log_dat[i], exp_dat[i]);
            check_eq($sformatf("%s.we%0d", tag, i), {31'd0, log_we[i]}, {31'd0, exp_we[i]});
            check_eq($sformatf("%s.sel%0d", tag, i), {28'd0, log_sel[i]}, 32'h0000_000F);
        end
        check_eq({tag, ".rep_n"}, 32'(replies.size()), 32'(exp_rep.size()));
        n = (replies.size() < exp_rep.size()) ? replies.size() : exp_rep.size();
        for (int i = 0; i < n; i++)
            check_eq($sformatf("%s.rep%0d", tag, i), {24'd0, replies[i]}, {24'd0, exp_rep[i]});
        log_adr.delete(); log_dat.delete(); log_we.delete(); log_sel.delete();
        replies.delete(); exp_adr.delete(); exp_dat.delete(); exp_we.delete(); exp_rep.delete();
    endtask

    // kind: 0 write, 1 read, 2 bad command, 3 write with long-but-legal gap,
    //       4 rx_error on byte nb, 5 partial frame of nb bytes then silence
    task automatic run_frame(input int kind, input logic [31:0] a, input logic [31:0] d,
                             input int nb, input string tag);
        logic [31:0] rv;
        logic [7:0]  cmd;
        int          n;
        fb[1] = a[31:24]; fb[2] = a[23:16]; fb[3] = a[15:8]; fb[4] = a[7:0];
        fb[5] = d[31:24]; fb[6] = d[23:16]; fb[7] = d[15:8]; fb[8] = d[7:0];
        case (kind)
            0, 3: begin
                fb[0] = 8'h57;
                fb_n  = 9;
                send_fb(-1, 4, (kind == 3) ? int'(BYTE_TO) - 15 : 0);
                check_eq({tag, ".cyc_lat"}, {31'd0, wb_cyc_o}, 32'd1);
                check_eq({tag, ".we_lat"}, {31'd0, wb_we_o}, 32'd1);
                exp_adr.push_back(a); exp_dat.push_back(d); exp_we.push_back(1'b1);
                ref_mem[a] = d;
                exp_rep.push_back(8'h06);
            end
            1: begin
                fb[0] = 8'h52;
                fb_n  = 5;
                send_fb(-1, -1, 0);
                check_eq({tag, ".cyc_lat"}, {31'd0, wb_cyc_o}, 32'd1);
                check_eq({tag, ".we_lat"}, {31'd0, wb_we_o}, 32'd0);
                rv = ref_mem.exists(a) ? ref_mem[a] : fill(a);
                exp_adr.push_back(a); exp_dat.push_back(rv); exp_we.push_back(1'b0);
                exp_rep.push_back(rv[31:24]); exp_rep.push_back(rv[23:16]);
                exp_rep.push_back(rv[15:8]);  exp_rep.push_back(rv[7:0]);
            end
            2: begin
                cmd = d[7:0];
                while (cmd == 8'h57 || cmd == 8'h52) cmd = 8'($urandom);
                fb[0] = cmd;
                fb_n  = 1;
                send_fb(-1, -1, 0);
                exp_rep.push_back(8'h15);
            end
            4: begin
                fb[0] = 8'h57;
                fb_n  = nb + 1;
                send_fb(nb, -1, 0);
            end
            5: begin
                fb[0] = 8'h57;
                fb_n  = nb;
                send_fb(-1, -1, 0);
                repeat (BYTE_TO + 10) @(posedge clk);
            end
            default: ;
        endcase
        n = 0;
        while (replies.size() < exp_rep.size() && n < 1000) begin
            @(posedge clk);
            n++;
        end
        repeat (8) @(posedge clk);
        compare_frame(tag);
    endtask

    initial begin
        int kind;
        logic [31:0] a;
        reset    = 1'b1;
        rx_data  = 8'h00;
        rx_avail = 1'b0;
        rx_error = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst.rx_ack", {31'd0, rx_ack}, 32'd0);
        check_eq("rst.tx_wr", {31'd0, tx_wr}, 32'd0);
        check_eq("rst.tx_data", {24'd0, tx_data}, 32'd0);
        check_eq("rst.adr", wb_adr_o, 32'd0);
        check_eq("rst.dat", wb_dat_o, 32'd0);
        check_eq("rst.sel", {28'd0, wb_sel_o}, 32'd0);
        check_eq("rst.ctl", {29'd0, wb_we_o, wb_cyc_o, wb_stb_o}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(posedge clk);

        run_frame(0, 32'h0000_1000, 32'hDEAD_BEEF, 0, "t1_write");
        slave_mem[32'h0000_1000] = 32'h1234_5678;
        ref_mem[32'h0000_1000]   = 32'h1234_5678;
        run_frame(1, 32'h0000_1000, 32'h0, 0, "t2_read");
        run_frame(2, 32'h0, 32'h41, 0, "t3_bad");
        run_frame(0, 32'h0000_1000, 32'hDEAD_BEEF, 0, "t3_write");
        run_frame(5, 32'h0000_1000, 32'h0, 3, "t4_partial");
        run_frame(1, 32'h0000_1000, 32'h0, 0, "t4_read");
        run_frame(4, 32'h0000_2000, 32'hCAFE_F00D, 2, "t5_rxerr");
        run_frame(0, 32'h0000_2000, 32'h0BAD_F00D, 0, "t5_write");
        run_frame(3, 32'h0000_3000, 32'h5555_AAAA, 0, "gap_ok");

        for (int i = 0; i < 40; i++) begin
            kind = $urandom_range(0, 9);
            a = ($urandom_range(0, 3) == 0) ? $urandom : (32'h1000_0000 | {27'd0, 3'($urandom), 2'b00});
            case (kind)
                0, 1, 2:  run_frame(0, a, $urandom, 0, $sformatf("r%0d_wr", i));
                3, 4, 5:  run_frame(1, a, 32'h0, 0, $sformatf("r%0d_rd", i));
                6:        run_frame(2, a, $urandom, 0, $sformatf("r%0d_bad", i));
                7:        run_frame(4, a, $urandom, $urandom_range(0, 8), $sformatf("r%0d_err", i));
                8:        run_frame(5, a, $urandom, $urandom_range(1, 8), $sformatf("r%0d_to", i));
                default:  run_frame(3, a, $urandom, 0, $sformatf("r%0d_gap", i));
            endcase
        end

        // Unresponsive slave, then reset in the middle of a cycle
        slave_en = 1'b0;
        fb[0] = 8'h52; fb[1] = 8'h00; fb[2] = 8'h00; fb[3] = 8'h40; fb[4] = 8'h00;
        fb_n  = 5;
        send_fb(-1, -1, 0);
        repeat (10) @(posedge clk);
        #1;
        check_eq("t6.cyc_held", {31'd0, wb_cyc_o}, 32'd1);
`ifdef BRIDGE_WB_TIMEOUT_EN
        begin
            int n;
            n = 0;
            while (replies.size() == 0 && n < int'(WB_TO) + 200) begin
                @(posedge clk);
                n++;
            end
            repeat (8) @(posedge clk);
            #1;
            check_eq("t6.cyc_drop", {31'd0, wb_cyc_o}, 32'd0);
            exp_rep.push_back(8'h15);
            compare_frame("t6_wbto");
            send_fb(-1, -1, 0);
            repeat (10) @(posedge clk);
            #1;
            check_eq("t6.cyc_held2", {31'd0, wb_cyc_o}, 32'd1);
        end
`else
        repeat (WB_TO + 100) @(posedge clk);
        #1;
        check_eq("t6.cyc_stuck", {31'd0, wb_cyc_o}, 32'd1);
`endif
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_eq("t6.rst_cyc", {30'd0, wb_cyc_o, wb_stb_o}, 32'd0);
        check_eq("t6.rst_tx", {31'd0, tx_wr}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (20) @(posedge clk);
        compare_frame("t6_rst");
        slave_en = 1'b1;
        run_frame(1, 32'h0000_1000, 32'h0, 0, "t6_recover");

        check_eq("rx_ack_double", 32'(ack_dbl), 32'd0);
        check_eq("tx_wr_double", 32'(wr_dbl), 32'd0);
        check_eq("tx_wr_busy", 32'(wr_busy), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
